// File: rtl/clk_switch_ctrl.sv
// Reference clock mux sequencer: qualifies the external clock, drives the mux select
// and MMCM reset, relocks with timeout/retry and latches a fault after repeated failures.
module clk_switch_ctrl #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned QUAL_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clk_ext_active,
  input  logic             locked,
  input  logic             user_int_select,
  input  logic             force_reset,
  output logic             clk_int_select,
  output logic             mmcm_resetn,
  output logic             using_ext,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] switch_count,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int unsigned TMR_W  = $clog2(SETTLE_CYCLES + LOCK_TIMEOUT + RESET_CYCLES + 1);
  localparam int unsigned QUAL_W = $clog2(QUAL_CYCLES + 1);
  localparam int unsigned RTRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0]  RST_LAST    = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WAIT_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  SETTLE_END  = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES + LOCK_TIMEOUT - 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST   = QUAL_W'(QUAL_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RTRY_LAST   = RTRY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN_INT   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN_EXT   = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  logic ext_meta_q, ext_s_q, lock_meta_q, lock_s_q;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [QUAL_W-1:0] qual_q, qual_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              tgt_ext_q, tgt_ext_d;
  logic [CNT_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [CNT_W-1:0]  ll_cnt_q, ll_cnt_d;
  logic              sel_q, sel_d;
  logic              rstn_q, rstn_d;
  logic              using_ext_q, using_ext_d;
  logic              fault_q, fault_d;
  logic              tmr_clr, lock_fail;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ext_meta_q  <= 1'b0;
      ext_s_q     <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      ext_meta_q  <= clk_ext_active;
      ext_s_q     <= ext_meta_q;
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_ext_d = tgt_ext_q;
    retry_d   = retry_q;
    qual_d    = '0;
    sw_cnt_d  = sw_cnt_q;
    ll_cnt_d  = ll_cnt_q;
    tmr_clr   = 1'b0;
    lock_fail = 1'b0;

    if (force_reset) begin
      state_d   = ST_RST;
      retry_d   = '0;
      tgt_ext_d = 1'b0;
      tmr_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q)                state_d   = ST_RUN_INT;
          else if (timer_q == WAIT_LAST) lock_fail = 1'b1;
        end
        ST_RUN_INT: begin
          if (ext_s_q && !user_int_select) begin
            if (qual_q == QUAL_LAST) begin
              state_d   = ST_SETTLE;
              tgt_ext_d = 1'b1;
            end else begin
              qual_d = qual_q + 1'b1;
            end
          end
          // A qualified switch this cycle takes precedence over lock loss.
          if (state_d == ST_RUN_INT && !lock_s_q) begin
            ll_cnt_d = (&ll_cnt_q) ? ll_cnt_q : ll_cnt_q + 1'b1;
            state_d  = ST_RST;
          end
        end
        ST_SETTLE: begin
          if (tgt_ext_q && !ext_s_q) begin
            tgt_ext_d = 1'b0;
            tmr_clr   = 1'b1;
          end else if (timer_q >= SETTLE_END && lock_s_q) begin
            if (tgt_ext_q) begin
              state_d  = ST_RUN_EXT;
              sw_cnt_d = (&sw_cnt_q) ? sw_cnt_q : sw_cnt_q + 1'b1;
            end else begin
              state_d = ST_RUN_INT;
            end
          end else if (timer_q == SETTLE_LAST) begin
            lock_fail = 1'b1;
          end
        end
        ST_RUN_EXT: begin
          if (!ext_s_q || user_int_select) begin
            state_d   = ST_SETTLE;
            tgt_ext_d = 1'b0;
          end else if (!lock_s_q) begin
            ll_cnt_d  = (&ll_cnt_q) ? ll_cnt_q : ll_cnt_q + 1'b1;
            state_d   = ST_RST;
            tgt_ext_d = 1'b0;
          end
        end
        ST_FAULT: begin
        end
        default: state_d = ST_RST;
      endcase

      if (lock_fail) begin
        retry_d   = retry_q + 1'b1;
        tgt_ext_d = 1'b0;
        state_d   = (retry_q == RTRY_LAST) ? ST_FAULT : ST_RST;
      end
    end

    if (state_d != state_q && (state_d == ST_RUN_INT || state_d == ST_RUN_EXT))
      retry_d = '0;

    // Timer restarts on every state change and only runs in the timed states.
    if (tmr_clr || state_d != state_q ||
        state_q == ST_RUN_INT || state_q == ST_RUN_EXT || state_q == ST_FAULT)
      timer_d = '0;
    else
      timer_d = timer_q + 1'b1;

    sel_d       = !((state_d == ST_SETTLE || state_d == ST_RUN_EXT) && tgt_ext_d);
    rstn_d      = (state_d != ST_RST);
    using_ext_d = (state_d == ST_RUN_EXT);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_RST;
      timer_q     <= '0;
      qual_q      <= '0;
      retry_q     <= '0;
      tgt_ext_q   <= 1'b0;
      sw_cnt_q    <= '0;
      ll_cnt_q    <= '0;
      sel_q       <= 1'b1;
      rstn_q      <= 1'b0;
      using_ext_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      qual_q      <= qual_d;
      retry_q     <= retry_d;
      tgt_ext_q   <= tgt_ext_d;
      sw_cnt_q    <= sw_cnt_d;
      ll_cnt_q    <= ll_cnt_d;
      sel_q       <= sel_d;
      rstn_q      <= rstn_d;
      using_ext_q <= using_ext_d;
      fault_q     <= fault_d;
    end
  end

  assign clk_int_select  = sel_q;
  assign mmcm_resetn     = rstn_q;
  assign using_ext       = using_ext_q;
  assign fault           = fault_q;
  assign state           = state_q;
  assign switch_count    = sw_cnt_q;
  assign lock_loss_count = ll_cnt_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: bring-up, qualification, ext loss, lock loss,
// relock timeout to fault, force_reset recovery and async reset.
module tb_clk_switch_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             aresetn, clk_ext_active, locked, user_int_select, force_reset;
  logic             clk_int_select, mmcm_resetn, using_ext, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] switch_count, lock_loss_count;

  int checks   = 0;
  int failures = 0;
  int n;

  clk_switch_ctrl #(
    .RESET_CYCLES (4),
    .QUAL_CYCLES  (8),
    .SETTLE_CYCLES(4),
    .LOCK_TIMEOUT (32),
    .MAX_RETRIES  (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .clk_ext_active (clk_ext_active),
    .locked         (locked),
    .user_int_select(user_int_select),
    .force_reset    (force_reset),
    .clk_int_select (clk_int_select),
    .mmcm_resetn    (mmcm_resetn),
    .using_ext      (using_ext),
    .fault          (fault),
    .state          (state),
    .switch_count   (switch_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; clk_ext_active = 1'b0; locked = 1'b0;
    user_int_select = 1'b0; force_reset = 1'b0;
    repeat (3) tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (clk_int_select !== 1'b1) begin failures++; $display("FAIL reset_sel got=%b exp=1", clk_int_select); end
    checks++; if (mmcm_resetn !== 1'b0) begin failures++; $display("FAIL reset_rstn got=%b exp=0", mmcm_resetn); end
    checks++; if ({using_ext, fault} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {using_ext, fault}); end
    checks++; if (switch_count !== '0 || lock_loss_count !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", switch_count, lock_loss_count); end
  endtask

  task automatic test_bringup();
    aresetn = 1'b1;
    n = 0; while (mmcm_resetn !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) begin failures++; $display("FAIL bringup_rst_low got=%0d exp=4", n); end
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL bringup_wait got=%0d exp=1", state); end
    repeat (6) tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL bringup_still_wait got=%0d exp=1", state); end
    locked = 1'b1;
    n = 0; while (state !== 3'd2 && n < 20) begin tick(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL bringup_lock_lat got=%0d exp=3", n); end
    checks++; if (clk_int_select !== 1'b1 || switch_count !== 16'd0) begin failures++; $display("FAIL bringup_run_int got=%b/%0d exp=1/0", clk_int_select, switch_count); end
  endtask

  task automatic test_qualify();
    clk_ext_active = 1'b1;
    repeat (7) tick();
    clk_ext_active = 1'b0;
    tick();
    clk_ext_active = 1'b1;
    n = 0; while (clk_int_select !== 1'b0 && n < 40) begin tick(); n++; end
    checks++; if (n !== 10) begin failures++; $display("FAIL qual_sel_lat got=%0d exp=10", n); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL qual_settle got=%0d exp=3", state); end
    n = 0; while (using_ext !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n !== 5) begin failures++; $display("FAIL qual_settle_len got=%0d exp=5", n); end
    checks++; if (state !== 3'd4 || switch_count !== 16'd1) begin failures++; $display("FAIL qual_run_ext got=%0d/%0d exp=4/1", state, switch_count); end
  endtask

  task automatic test_ext_loss();
    clk_ext_active = 1'b0;
    n = 0; while (clk_int_select !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL extloss_sel_lat got=%0d exp=3", n); end
    checks++; if (state !== 3'd3 || using_ext !== 1'b0) begin failures++; $display("FAIL extloss_settle got=%0d/%b exp=3/0", state, using_ext); end
    n = 0; while (state !== 3'd2 && n < 40) begin tick(); n++; end
    checks++; if (n !== 5) begin failures++; $display("FAIL extloss_to_int got=%0d exp=5", n); end
    checks++; if (lock_loss_count !== 16'd0) begin failures++; $display("FAIL extloss_llcnt got=%0d exp=0", lock_loss_count); end
  endtask

  task automatic test_lock_loss();
    int sel_low;
    clk_ext_active = 1'b1;
    n = 0; while (using_ext !== 1'b1 && n < 60) begin tick(); n++; end
    checks++; if (n !== 15 || switch_count !== 16'd2) begin failures++; $display("FAIL requal got=%0d/%0d exp=15/2", n, switch_count); end
    locked = 1'b0;
    n = 0; while (mmcm_resetn !== 1'b0 && n < 20) begin tick(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL lockloss_lat got=%0d exp=3", n); end
    checks++; if (lock_loss_count !== 16'd1) begin failures++; $display("FAIL lockloss_cnt got=%0d exp=1", lock_loss_count); end
    checks++; if (state !== 3'd0 || clk_int_select !== 1'b1 || using_ext !== 1'b0) begin failures++; $display("FAIL lockloss_rst got=%0d/%b/%b exp=0/1/0", state, clk_int_select, using_ext); end
    user_int_select = 1'b1; locked = 1'b1;
    n = 0; while (mmcm_resetn !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) begin failures++; $display("FAIL lockloss_rst_low got=%0d exp=4", n); end
    n = 0; while (state !== 3'd2 && n < 20) begin tick(); n++; end
    checks++; if (n !== 1) begin failures++; $display("FAIL relock_lat got=%0d exp=1", n); end
    sel_low = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (clk_int_select !== 1'b1) sel_low++; end
    checks++; if (sel_low !== 0 || state !== 3'd2) begin failures++; $display("FAIL user_int_hold got=%0d/%0d exp=0/2", sel_low, state); end
  endtask

  task automatic test_timeout_fault();
    locked = 1'b0;
    n = 0; while (fault !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n !== 75) begin failures++; $display("FAIL fault_lat got=%0d exp=75", n); end
    repeat (5) tick();
    checks++; if (state !== 3'd5 || fault !== 1'b1) begin failures++; $display("FAIL fault_hold got=%0d/%b exp=5/1", state, fault); end
    checks++; if (clk_int_select !== 1'b1 || mmcm_resetn !== 1'b1) begin failures++; $display("FAIL fault_outs got=%b/%b exp=1/1", clk_int_select, mmcm_resetn); end
    checks++; if (lock_loss_count !== 16'd2) begin failures++; $display("FAIL fault_llcnt got=%0d exp=2", lock_loss_count); end
    force_reset = 1'b1; tick(); force_reset = 1'b0;
    checks++; if (state !== 3'd0 || fault !== 1'b0 || mmcm_resetn !== 1'b0) begin failures++; $display("FAIL force_rst got=%0d/%b/%b exp=0/0/0", state, fault, mmcm_resetn); end
    checks++; if (switch_count !== 16'd2 || lock_loss_count !== 16'd2) begin failures++; $display("FAIL force_cnt_keep got=%0d/%0d exp=2/2", switch_count, lock_loss_count); end
    n = 0; while (fault !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n !== 72) begin failures++; $display("FAIL retry_cleared got=%0d exp=72", n); end
    force_reset = 1'b1; locked = 1'b1; tick(); force_reset = 1'b0;
    n = 0; while (state !== 3'd2 && n < 50) begin tick(); n++; end
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL recover_run_int got=%0d exp=2", state); end
  endtask

  task automatic test_async_reset();
    user_int_select = 1'b0;
    n = 0; while (state !== 3'd3 && n < 50) begin tick(); n++; end
    checks++; if (state !== 3'd3 || clk_int_select !== 1'b0) begin failures++; $display("FAIL pre_reset_settle got=%0d/%b exp=3/0", state, clk_int_select); end
    repeat (2) tick();
    #3 aresetn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || clk_int_select !== 1'b1 || mmcm_resetn !== 1'b0) begin failures++; $display("FAIL async_rst_outs got=%0d/%b/%b exp=0/1/0", state, clk_int_select, mmcm_resetn); end
    checks++; if (using_ext !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL async_rst_flags got=%b/%b exp=0/0", using_ext, fault); end
    checks++; if (switch_count !== 16'd0 || lock_loss_count !== 16'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", switch_count, lock_loss_count); end
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_qualify();
    test_ext_loss();
    test_lock_loss();
    test_timeout_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim time expired before summary");
    $fatal(1);
  end

endmodule
